cc_cond_unit: RTL and testbench
===============================

Name: cc_cond_unit

Overview:
Execute-stage companion to the 64-bit SEQ ALU. It decodes icode/ifun into the ALU function select (S1,S0) and consumes the ALU result and overflow flag. It holds the architectural condition codes ZF, SF and OF in a register, and produces the Cnd signal that jXX and cmovXX use in the same cycle. This is the only state-holding element of the execute stage.

Parameters:
- WIDTH, 64, datapath width of the ALU result.
- CC_RESET, 3'b100, reset value of {ZF,SF,OF}; the Y86-64 architectural reset is ZF=1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- icode  input  4  instruction code of the current instruction.
- ifun  input  4  function code of the current instruction.
- stat_ok  input  1  1 when the current instruction raised no exception (AOK).
- hold  input  1  1 freezes the CC register (stall or bubble).
- alu_out  input  WIDTH  ALU result, valE.
- alu_ovf  input  1  ALU signed-overflow output.
- alu_s1  output  1  ALU function select, high bit.
- alu_s0  output  1  ALU function select, low bit.
- zf  output  1  registered zero flag.
- sf  output  1  registered sign flag.
- of  output  1  registered overflow flag.
- cnd  output  1  condition result for the current jXX or cmovXX.
- set_cc  output  1  1 when the CC register loads at the next edge (debug/trace).

Behaviour:
- Function select (combinational):
  - icode==6 (OPq): {alu_s1,alu_s0}=ifun[1:0]. 00=add, 01=sub, 10=and, 11=xor.
  - All other icodes: 00 (add), used for address and stack arithmetic.
  - OPq with ifun>3 is invalid: select is 00, and set_cc=0.
- set_cc = (icode==6) & (ifun<=3) & stat_ok & ~hold.
- CC register update, on posedge clk when set_cc=1:
  - ZF <= (alu_out==0).
  - SF <= alu_out[WIDTH-1].
  - OF <= alu_ovf for add/sub; OF <= 0 for and/xor, forced here regardless of alu_ovf.
- When set_cc=0 the CC register holds its value.
- Reset: asserting rst_n=0 sets {zf,sf,of}=CC_RESET immediately, without waiting for a clock edge. This applies mid-instruction too; any pending update is lost. Release is synchronous to the next clk edge.
- cnd (combinational, from registered flags only, never from the in-flight ALU result):
  - ifun 0 always: 1.
  - ifun 1 le: (SF^OF)|ZF.
  - ifun 2 l: SF^OF.
  - ifun 3 e: ZF.
  - ifun 4 ne: ~ZF.
  - ifun 5 ge: ~(SF^OF).
  - ifun 6 g: ~(SF^OF)&~ZF.
  - ifun >=7: 0.
  - cnd is driven only for icode 7 (jXX) or 2 (cmovXX/rrmovq); for all other icodes cnd=0.
- Latency:
  - The flag written by an OPq is visible to cnd one cycle later, i.e. to the next instruction.
  - Select decode has zero latency.
- Simultaneous events:
  - hold=1 with a valid OPq: no update. hold takes priority over set_cc.
  - An exception (stat_ok=0) suppresses the update.
  - rst_n=0 overrides everything.
- Width rule: ZF compares all WIDTH bits. SF is bit WIDTH-1 only.
- Reset values of outputs:
  - zf=1, sf=0, of=0.
  - cnd follows the reset flags (e.g. jle reads 1).
  - alu_s1/alu_s0 and set_cc are purely combinational from the inputs.

Decomposition:
- Shared package y86_pkg:
  - icode constants: IRRMOVQ=2, IOPQ=6, IJXX=7.
  - ALU function constants: ALUADD/ALUSUB/ALUAND/ALUXOR.
  - condition constants: C_YES, C_LE, C_L, C_E, C_NE, C_GE, C_G.
  - CC bit-index constants.
- One natural sub-module, cond_eval: purely combinational, maps (ifun, zf, sf, of) to cnd. It is reused later by the pipelined version.

Test Plan:
- Reset: rst_n=0 asynchronously, no clk -> zf=1, sf=0, of=0 at once. Then icode=7, ifun=3 -> cnd=1.
- subq: icode=6, ifun=1, alu_out=64'h8000_0000_0000_0000, alu_ovf=1, stat_ok=1 -> alu_s1/s0=01. After the edge: zf=0, sf=1, of=1. Then jl (icode=7, ifun=2) -> cnd=0, and jge -> cnd=1.
- andq: ifun=2, alu_out=0, alu_ovf=1 -> after the edge zf=1, sf=0, of=0 (forced). Then cmovne (icode=2, ifun=4) -> cnd=0.
- Suppression: addq with stat_ok=0, or with hold=1, alu_out=5 -> flags unchanged and set_cc=0. Invalid OPq ifun=9 -> flags unchanged, select=00.
- Non-OPq: icode=4 (rmmovq) -> select=00, cnd=0, flags unchanged. jXX with ifun=7 -> cnd=0.
- Mid-operation reset: assert rst_n low between edges after flags={0,1,1} -> flags return to {1,0,0} with no clock edge. The next OPq edge after release updates normally.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 execute-stage encodings (icodes, ALU functions,
// condition codes and CC bit positions).
package y86_pkg;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;

   typedef enum logic [1:0] {
      ALUADD = 2'b00,
      ALUSUB = 2'b01,
      ALUAND = 2'b10,
      ALUXOR = 2'b11
   } alu_fn_e;

   localparam logic [3:0] C_YES = 4'h0;
   localparam logic [3:0] C_LE  = 4'h1;
   localparam logic [3:0] C_L   = 4'h2;
   localparam logic [3:0] C_E   = 4'h3;
   localparam logic [3:0] C_NE  = 4'h4;
   localparam logic [3:0] C_GE  = 4'h5;
   localparam logic [3:0] C_G   = 4'h6;

   localparam int CC_ZF = 2;
   localparam int CC_SF = 1;
   localparam int CC_OF = 0;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: maps a jXX/cmovXX function code and the condition flags to cnd.
module cond_eval
   import y86_pkg::*;
(
   input  logic [3:0] ifun,
   input  logic       zf,
   input  logic       sf,
   input  logic       of,
   output logic       cnd
);
   logic lt;
   assign lt = sf ^ of;
   always_comb begin
      cnd = 1'b0;
      case (ifun)
         C_YES:   cnd = 1'b1;
         C_LE:    cnd = lt | zf;
         C_L:     cnd = lt;
         C_E:     cnd = zf;
         C_NE:    cnd = ~zf;
         C_GE:    cnd = ~lt;
         C_G:     cnd = ~lt & ~zf;
         default: cnd = 1'b0;
      endcase
   end
endmodule

// File: rtl/cc_cond_unit.sv
// cc_cond_unit: ALU function decode, architectural condition-code register
// and the same-cycle branch/cmov condition for the SEQ execute stage.
module cc_cond_unit
   import y86_pkg::*;
#(
   parameter int         WIDTH    = 64,
   parameter logic [2:0] CC_RESET = 3'b100
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       icode,
   input  logic [3:0]       ifun,
   input  logic             stat_ok,
   input  logic             hold,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_ovf,
   output logic             alu_s1,
   output logic             alu_s0,
   output logic             zf,
   output logic             sf,
   output logic             of,
   output logic             cnd,
   output logic             set_cc
);
   logic    op_ok;
   logic    cnd_raw;
   alu_fn_e sel;
   logic [2:0] cc;

   assign op_ok  = (icode == IOPQ) && (ifun <= 4'd3);
   assign sel    = op_ok ? alu_fn_e'(ifun[1:0]) : ALUADD;
   assign {alu_s1, alu_s0} = sel;
   assign set_cc = op_ok & stat_ok & ~hold;

   // Logical ops cannot overflow, so OF is cleared rather than trusting the ALU.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cc <= CC_RESET;
      else if (set_cc) begin
         cc[CC_ZF] <= (alu_out == '0);
         cc[CC_SF] <= alu_out[WIDTH-1];
         cc[CC_OF] <= (sel == ALUADD || sel == ALUSUB) ? alu_ovf : 1'b0;
      end
   end

   assign zf = cc[CC_ZF];
   assign sf = cc[CC_SF];
   assign of = cc[CC_OF];

   cond_eval u_cond (
      .ifun (ifun),
      .zf   (zf),
      .sf   (sf),
      .of   (of),
      .cnd  (cnd_raw)
   );

   assign cnd = ((icode == IJXX) || (icode == IRRMOVQ)) & cnd_raw;
endmodule

// File: tb/tb_cc_cond_unit.sv
// tb_cc_cond_unit: vector table plus hand sequences for async reset behaviour;
// post-edge flag expectations travel through a scoreboard queue.
module tb_cc_cond_unit;
   typedef struct {
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic        stat_ok;
      logic        hold;
      logic [63:0] alu_out;
      logic        alu_ovf;
      logic [1:0]  sel;
      logic        set;
      logic        cnd;
      logic [2:0]  flags;
   } vec_t;

   logic        clk = 1'b0, clk_en = 1'b0, rst_n = 1'b1;
   logic [3:0]  icode = '0, ifun = '0;
   logic        stat_ok = 1'b1, hold = 1'b0, alu_ovf = 1'b0;
   logic [63:0] alu_out = '0;
   logic        alu_s1, alu_s0, zf, sf, of, cnd, set_cc;

   int n_cmp = 0, n_err = 0;
   vec_t tbl[$];
   logic [2:0] sb[$];

   cc_cond_unit #(.WIDTH(64), .CC_RESET(3'b100)) dut (
      .clk(clk), .rst_n(rst_n), .icode(icode), .ifun(ifun), .stat_ok(stat_ok),
      .hold(hold), .alu_out(alu_out), .alu_ovf(alu_ovf), .alu_s1(alu_s1),
      .alu_s0(alu_s0), .zf(zf), .sf(sf), .of(of), .cnd(cnd), .set_cc(set_cc)
   );

   always #5 if (clk_en) clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] ic, input logic [3:0] fn, input logic ok,
                      input logic hd, input logic [63:0] v, input logic ov,
                      input logic [1:0] s, input logic st, input logic c,
                      input logic [2:0] f);
      tbl.push_back('{ic, fn, ok, hd, v, ov, s, st, c, f});
   endtask

   task automatic drive(input vec_t v);
      icode = v.icode; ifun = v.ifun; stat_ok = v.stat_ok;
      hold = v.hold; alu_out = v.alu_out; alu_ovf = v.alu_ovf;
   endtask

   task automatic apply(input vec_t v, input string tag);
      logic [2:0] e;
      @(negedge clk);
      drive(v);
      #1;
      chk({tag, " sel"}, {62'd0, alu_s1, alu_s0}, {62'd0, v.sel});
      chk({tag, " set_cc"}, {63'd0, set_cc}, {63'd0, v.set});
      chk({tag, " cnd"}, {63'd0, cnd}, {63'd0, v.cnd});
      sb.push_back(v.flags);
      @(posedge clk);
      #1;
      if (sb.size() == 0) chk({tag, " scoreboard empty"}, 64'd1, 64'd0);
      else begin
         e = sb.pop_front();
         chk({tag, " flags"}, {61'd0, zf, sf, of}, {61'd0, e});
      end
   endtask

   initial begin
      vec_t v;
      //   icode ifun ok hold alu_out                 ovf sel set cnd flags
      add(4'h7, 4'h3, 1, 0, 64'd0,                   0, 2'b00, 0, 1, 3'b100); // je after reset
      add(4'h7, 4'h1, 1, 0, 64'd0,                   0, 2'b00, 0, 1, 3'b100); // jle after reset
      add(4'h6, 4'h1, 1, 0, 64'h8000_0000_0000_0000, 1, 2'b01, 1, 0, 3'b011); // subq
      add(4'h7, 4'h2, 1, 0, 64'd0,                   0, 2'b00, 0, 0, 3'b011); // jl
      add(4'h7, 4'h5, 1, 0, 64'd0,                   0, 2'b00, 0, 1, 3'b011); // jge
      add(4'h7, 4'h1, 1, 0, 64'd0,                   0, 2'b00, 0, 0, 3'b011); // jle
      add(4'h7, 4'h4, 1, 0, 64'd0,                   0, 2'b00, 0, 1, 3'b011); // jne
      add(4'h7, 4'h6, 1, 0, 64'd0,                   0, 2'b00, 0, 1, 3'b011); // jg
      add(4'h7, 4'h0, 1, 0, 64'd0,                   0, 2'b00, 0, 1, 3'b011); // jmp
      add(4'h7, 4'h7, 1, 0, 64'd0,                   0, 2'b00, 0, 0, 3'b011); // ifun 7
      add(4'h6, 4'h2, 1, 0, 64'd0,                   1, 2'b10, 1, 0, 3'b100); // andq, OF forced 0
      add(4'h2, 4'h4, 1, 0, 64'd0,                   0, 2'b00, 0, 0, 3'b100); // cmovne
      add(4'h2, 4'h3, 1, 0, 64'd0,                   0, 2'b00, 0, 1, 3'b100); // cmove
      add(4'h6, 4'h0, 0, 0, 64'd5,                   1, 2'b00, 0, 0, 3'b100); // addq exception
      add(4'h6, 4'h0, 1, 1, 64'd5,                   1, 2'b00, 0, 0, 3'b100); // addq hold
      add(4'h6, 4'h9, 1, 0, 64'd5,                   1, 2'b00, 0, 0, 3'b100); // invalid OPq
      add(4'h4, 4'h3, 1, 0, 64'd5,                   1, 2'b00, 0, 0, 3'b100); // rmmovq
      add(4'h6, 4'h3, 1, 0, 64'd1,                   1, 2'b11, 1, 0, 3'b000); // xorq, OF forced 0
      add(4'h7, 4'h2, 1, 0, 64'd0,                   0, 2'b00, 0, 0, 3'b000); // jl
      add(4'h6, 4'h0, 1, 0, 64'h8000_0000_0000_0001, 0, 2'b00, 1, 0, 3'b010); // addq negative
      add(4'h7, 4'h2, 1, 0, 64'd0,                   0, 2'b00, 0, 1, 3'b010); // jl
      add(4'h7, 4'h5, 1, 0, 64'd0,                   0, 2'b00, 0, 0, 3'b010); // jge
      add(4'h6, 4'h0, 1, 0, 64'h0000_0001_0000_0000, 0, 2'b00, 1, 0, 3'b000); // upper bits only
      add(4'h6, 4'h1, 1, 0, 64'd0,                   0, 2'b01, 1, 0, 3'b100); // subq to zero
      add(4'h2, 4'h1, 1, 0, 64'd0,                   0, 2'b00, 0, 1, 3'b100); // cmovle

      // Asynchronous reset with the clock stopped.
      rst_n = 1'b0;
      #1;
      chk("async reset flags", {61'd0, zf, sf, of}, 64'b100);
      clk_en = 1'b1;
      #12;
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

      // Mid-instruction reset drops the pending update.
      v = '{4'h6, 4'h1, 1, 0, 64'h8000_0000_0000_0000, 1, 2'b01, 1, 0, 3'b011};
      apply(v, "pre-reset subq");
      @(negedge clk);
      v.alu_out = 64'd0;
      v.alu_ovf = 1'b0;
      drive(v);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid reset flags", {61'd0, zf, sf, of}, 64'b100);
      @(posedge clk);
      #1;
      chk("held reset flags", {61'd0, zf, sf, of}, 64'b100);
      @(negedge clk);
      rst_n = 1'b1;
      v = '{4'h6, 4'h0, 1, 0, 64'h8000_0000_0000_0000, 0, 2'b00, 1, 0, 3'b010};
      drive(v);
      @(posedge clk);
      #1;
      chk("post-release addq flags", {61'd0, zf, sf, of}, 64'b010);

      chk("scoreboard drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
